bypass_net: RTL and testbench

//  Parametrised operand-bypass network for the ID stage: resolves NUM_RD register reads against NUM_SRC in-flight producers (EX, MEM, WB).

---
 rtl/bypass_net_pkg.sv | 8 +
 rtl/bypass_net_port.sv | 84 ++++++++
 rtl/bypass_net.sv | 65 ++++++
 tb/tb_bypass_net.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_net_pkg.sv
// Shared constants for the ID-stage operand bypass network.
// Sizing defaults plus the hard-wired zero register address.
package bypass_net_pkg;
    localparam int NUM_RD_DEF  = 2;
    localparam int NUM_SRC_DEF = 3;
    localparam int REG_AW_DEF  = 5;
    localparam int ZERO_REG    = 0;
endpackage

// File: rtl/bypass_net_port.sv
// One read port of the bypass network: youngest-wins producer match,
// load-use pending detection and the per-port operand hold register.
module bypass_port
    import bypass_net_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      stall_id,
    input  logic                      rd_en,
    input  logic [REG_AW-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_SRC-1:0]        src_we,
    input  logic [NUM_SRC*REG_AW-1:0] src_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
    input  logic [NUM_SRC-1:0]        src_rdy,
    output logic [DATA_W-1:0]         opnd_data,
    output logic                      opnd_fwd,
    output logic                      pend
);
    logic                 is_zero;
    logic [NUM_SRC-1:0]   match;
    logic                 hit;
    logic                 win_rdy;
    logic [DATA_W-1:0]    win_data;
    logic                 hold_vld_reg;
    logic [DATA_W-1:0]    hold_data_reg;

    assign is_zero = rd_en && (rd_addr == REG_AW'(ZERO_REG));

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
        assign match[gi] = rd_en && src_we[gi] && !is_zero &&
                           (src_waddr[gi*REG_AW +: REG_AW] == rd_addr);
    end

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit      = 1'b0;
        win_rdy  = 1'b0;
        win_data = '0;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (match[s]) begin
                hit      = 1'b1;
                win_rdy  = src_rdy[s];
                win_data = src_wdata[s*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        opnd_data = rf_data;
        opnd_fwd  = 1'b0;
        pend      = 1'b0;
        if (hold_vld_reg) begin
            opnd_data = hold_data_reg;
            opnd_fwd  = 1'b1;
        end else if (is_zero) begin
            opnd_data = '0;
        end else if (hit && win_rdy) begin
            opnd_data = win_data;
            opnd_fwd  = 1'b1;
        end else if (hit) begin
            opnd_data = '0;
            pend      = 1'b1;
        end
    end

    // Once captured, the hold wins over any later producer until ID advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld_reg  <= 1'b0;
            hold_data_reg <= '0;
        end else if (flush || !stall_id) begin
            hold_vld_reg  <= 1'b0;
        end else if (!hold_vld_reg && !pend && rd_en) begin
            hold_vld_reg  <= 1'b1;
            hold_data_reg <= opnd_data;
        end
    end
endmodule

// File: rtl/bypass_net.sv
// ID-stage operand bypass: one bypass_port per read port, load-use stall
// request and a saturating count of stalled cycles.
module bypass_net
    import bypass_net_pkg::*;
#(
    parameter int NUM_RD  = NUM_RD_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      stall_id,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD*REG_AW-1:0]  rd_addr,
    input  logic [NUM_RD*DATA_W-1:0]  rf_data,
    input  logic [NUM_SRC-1:0]        src_we,
    input  logic [NUM_SRC*REG_AW-1:0] src_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
    input  logic [NUM_SRC-1:0]        src_rdy,
    output logic [NUM_RD*DATA_W-1:0]  opnd_data,
    output logic [NUM_RD-1:0]         opnd_fwd,
    output logic                      load_use_stall,
    output logic [CNT_W-1:0]          lu_cnt
);
    logic [NUM_RD-1:0] pend;
    logic [CNT_W-1:0]  lu_cnt_reg;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        bypass_port #(
            .NUM_SRC (NUM_SRC),
            .DATA_W  (DATA_W),
            .REG_AW  (REG_AW)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .stall_id  (stall_id),
            .rd_en     (rd_en[gi]),
            .rd_addr   (rd_addr[gi*REG_AW +: REG_AW]),
            .rf_data   (rf_data[gi*DATA_W +: DATA_W]),
            .src_we    (src_we),
            .src_waddr (src_waddr),
            .src_wdata (src_wdata),
            .src_rdy   (src_rdy),
            .opnd_data (opnd_data[gi*DATA_W +: DATA_W]),
            .opnd_fwd  (opnd_fwd[gi]),
            .pend      (pend[gi])
        );
    end

    assign load_use_stall = |pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt_reg <= '0;
        end else if (load_use_stall && !flush && (lu_cnt_reg != {CNT_W{1'b1}})) begin
            lu_cnt_reg <= lu_cnt_reg + 1'b1;
        end
    end

    assign lu_cnt = lu_cnt_reg;
endmodule

// File: tb/tb_bypass_net.sv
// Directed bench for bypass_net: combinational vector table plus
// multi-cycle sequences for load-use, hold, flush, reset and saturation.
module tb_bypass_net;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush, stall_id;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rf_data;
    logic [2:0]  src_we;
    logic [14:0] src_waddr;
    logic [95:0] src_wdata;
    logic [2:0]  src_rdy;
    logic [63:0] opnd_data, opnd_data4;
    logic [1:0]  opnd_fwd, opnd_fwd4;
    logic        load_use_stall, stall4;
    logic [15:0] lu_cnt;
    logic [3:0]  lu_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bypass_net #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
        .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
        .src_we(src_we), .src_waddr(src_waddr), .src_wdata(src_wdata), .src_rdy(src_rdy),
        .opnd_data(opnd_data), .opnd_fwd(opnd_fwd),
        .load_use_stall(load_use_stall), .lu_cnt(lu_cnt)
    );

    bypass_net #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
        .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
        .src_we(src_we), .src_waddr(src_waddr), .src_wdata(src_wdata), .src_rdy(src_rdy),
        .opnd_data(opnd_data4), .opnd_fwd(opnd_fwd4),
        .load_use_stall(stall4), .lu_cnt(lu_cnt4)
    );

    typedef struct {
        logic [1:0]  rd_en;
        logic [9:0]  rd_addr;
        logic [63:0] rf_data;
        logic [2:0]  we;
        logic [14:0] waddr;
        logic [95:0] wdata;
        logic [2:0]  rdy;
        logic [63:0] exp_data;
        logic [1:0]  exp_fwd;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        flush = 0; stall_id = 0; rd_en = 0; rd_addr = 0; rf_data = 0;
        src_we = 0; src_waddr = 0; src_wdata = 0; src_rdy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic chk_port0(input string name, input logic [31:0] d, input logic f);
        chk({name, "_data0"}, {32'h0, opnd_data[31:0]}, {32'h0, d});
        chk({name, "_fwd0"}, {63'h0, opnd_fwd[0]}, {63'h0, f});
    endtask

    initial begin
        vecs[0] = '{rd_en:2'b01, rd_addr:{5'd0,5'd8}, rf_data:{32'h77,32'h0},
                    we:3'b111, waddr:{5'd8,5'd8,5'd8}, wdata:{32'h33,32'h22,32'h11}, rdy:3'b111,
                    exp_data:{32'h77,32'h11}, exp_fwd:2'b01, exp_stall:1'b0};
        vecs[1] = '{rd_en:2'b01, rd_addr:{5'd0,5'd8}, rf_data:{32'h0,32'hAA},
                    we:3'b011, waddr:{5'd0,5'd8,5'd8}, wdata:{32'h0,32'h22,32'h11}, rdy:3'b010,
                    exp_data:{32'h0,32'h0}, exp_fwd:2'b00, exp_stall:1'b1};
        vecs[2] = '{rd_en:2'b11, rd_addr:{5'd0,5'd0}, rf_data:{32'h1234,32'h5678},
                    we:3'b001, waddr:{5'd0,5'd0,5'd0}, wdata:{32'h0,32'h0,32'hFFFF}, rdy:3'b111,
                    exp_data:{32'h0,32'h0}, exp_fwd:2'b00, exp_stall:1'b0};
        vecs[3] = '{rd_en:2'b11, rd_addr:{5'd4,5'd3}, rf_data:{32'hBBBB,32'hAAAA},
                    we:3'b111, waddr:{5'd7,5'd6,5'd5}, wdata:{32'h3,32'h2,32'h1}, rdy:3'b111,
                    exp_data:{32'hBBBB,32'hAAAA}, exp_fwd:2'b00, exp_stall:1'b0};
        vecs[4] = '{rd_en:2'b00, rd_addr:{5'd6,5'd5}, rf_data:{32'hC,32'hD},
                    we:3'b111, waddr:{5'd7,5'd6,5'd5}, wdata:{32'h3,32'h2,32'h1}, rdy:3'b000,
                    exp_data:{32'hC,32'hD}, exp_fwd:2'b00, exp_stall:1'b0};
        vecs[5] = '{rd_en:2'b11, rd_addr:{5'd3,5'd2}, rf_data:{32'h0,32'h0},
                    we:3'b111, waddr:{5'd2,5'd3,5'd9}, wdata:{32'h44,32'h55,32'h66}, rdy:3'b111,
                    exp_data:{32'h55,32'h44}, exp_fwd:2'b11, exp_stall:1'b0};
        vecs[6] = '{rd_en:2'b11, rd_addr:{5'd2,5'd2}, rf_data:{32'h0,32'h0},
                    we:3'b110, waddr:{5'd2,5'd7,5'd2}, wdata:{32'h44,32'h55,32'h66}, rdy:3'b111,
                    exp_data:{32'h44,32'h44}, exp_fwd:2'b11, exp_stall:1'b0};
        vecs[7] = '{rd_en:2'b10, rd_addr:{5'd9,5'd0}, rf_data:{32'h0,32'h10},
                    we:3'b111, waddr:{5'd9,5'd9,5'd9}, wdata:{32'h3,32'h2,32'h1}, rdy:3'b110,
                    exp_data:{32'h0,32'h10}, exp_fwd:2'b00, exp_stall:1'b1};

        // Reset state: hold cleared, operands straight from the regfile.
        clear_inputs();
        rd_en = 2'b11; rd_addr = {5'd1,5'd2}; rf_data = {32'h2,32'h1};
        #1;
        chk("reset_data", opnd_data, {32'h2,32'h1});
        chk("reset_fwd", {62'h0, opnd_fwd}, 64'h0);
        chk("reset_cnt", {48'h0, lu_cnt}, 64'h0);
        $display("reset state checked");
        @(negedge clk);
        rst = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr; rf_data = vecs[i].rf_data;
            src_we = vecs[i].we; src_waddr = vecs[i].waddr; src_wdata = vecs[i].wdata;
            src_rdy = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_data", i), opnd_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_fwd", i), {62'h0, opnd_fwd}, {62'h0, vecs[i].exp_fwd});
            chk($sformatf("vec%0d_stall", i), {63'h0, load_use_stall}, {63'h0, vecs[i].exp_stall});
            $display("vector %0d applied", i);
        end

        // Load-use on port 1 while port 0 captures a WB forward.
        do_reset();
        stall_id = 1; rd_en = 2'b11; rd_addr = {5'd9,5'd4}; rf_data = {32'h0,32'hDEAD};
        src_we = 3'b101; src_waddr = {5'd4,5'd0,5'd9}; src_wdata = {32'h44,32'h0,32'h0}; src_rdy = 3'b100;
        #1;
        chk("lu_c0_data", opnd_data, {32'h0,32'h44});
        chk("lu_c0_fwd", {62'h0, opnd_fwd}, 64'h1);
        chk("lu_c0_stall", {63'h0, load_use_stall}, 64'h1);
        chk("lu_c0_cnt", {48'h0, lu_cnt}, 64'h0);
        $display("load-use cycle 0");
        @(negedge clk);
        stall_id = 0; rf_data = {32'h1111,32'hDEAD};
        src_we = 3'b010; src_waddr = {5'd0,5'd9,5'd0}; src_wdata = {32'h0,32'hABCD,32'h0}; src_rdy = 3'b010;
        #1;
        chk("lu_c1_data", opnd_data, {32'hABCD,32'h44});
        chk("lu_c1_fwd", {62'h0, opnd_fwd}, 64'h3);
        chk("lu_c1_stall", {63'h0, load_use_stall}, 64'h0);
        chk("lu_c1_cnt", {48'h0, lu_cnt}, 64'h1);
        $display("load-use cycle 1");
        @(negedge clk);
        src_we = 3'b000;
        #1;
        chk("lu_c2_data", opnd_data, {32'h1111,32'hDEAD});
        chk("lu_c2_fwd", {62'h0, opnd_fwd}, 64'h0);
        $display("load-use cycle 2");

        // Hold across a 3-cycle stall with stale regfile and a later producer.
        do_reset();
        stall_id = 1; rd_en = 2'b01; rd_addr = {5'd0,5'd4}; rf_data = {32'h0,32'hDEAD};
        src_we = 3'b100; src_waddr = {5'd4,5'd0,5'd0}; src_wdata = {32'h5,32'h0,32'h0}; src_rdy = 3'b111;
        #1; chk_port0("hold_c0", 32'h5, 1'b1); $display("hold cycle 0");
        @(negedge clk);
        src_we = 3'b000;
        #1; chk_port0("hold_c1", 32'h5, 1'b1); $display("hold cycle 1");
        @(negedge clk);
        src_we = 3'b001; src_waddr = {5'd0,5'd0,5'd4}; src_wdata = {32'h0,32'h0,32'h99};
        #1; chk_port0("hold_c2", 32'h5, 1'b1); $display("hold cycle 2");
        @(negedge clk);
        stall_id = 0; src_we = 3'b000;
        #1; chk_port0("hold_c3", 32'h5, 1'b1); $display("hold release cycle");
        @(negedge clk);
        #1; chk_port0("hold_c4", 32'hDEAD, 1'b0); $display("hold consumed");

        // Flush with stall, then reset mid-stall.
        do_reset();
        stall_id = 1; rd_en = 2'b11; rd_addr = {5'd9,5'd4}; rf_data = {32'h0,32'hDEAD};
        src_we = 3'b101; src_waddr = {5'd4,5'd0,5'd9}; src_wdata = {32'h5,32'h0,32'h0}; src_rdy = 3'b100;
        @(negedge clk);
        flush = 1; src_we = 3'b001;
        #1;
        chk_port0("flush_c1", 32'h5, 1'b1);
        chk("flush_c1_cnt", {48'h0, lu_cnt}, 64'h1);
        $display("flush cycle");
        @(negedge clk);
        flush = 0;
        #1;
        chk_port0("flush_c2", 32'hDEAD, 1'b0);
        chk("flush_c2_cnt", {48'h0, lu_cnt}, 64'h1);
        $display("after flush");
        @(negedge clk);
        rf_data = {32'h0,32'hBEEF};
        #1;
        chk_port0("rst_pre", 32'hDEAD, 1'b1);
        chk("rst_pre_cnt", {48'h0, lu_cnt}, 64'h2);
        #1; rst = 0; #1;
        chk_port0("rst_mid", 32'hBEEF, 1'b0);
        chk("rst_mid_cnt", {48'h0, lu_cnt}, 64'h0);
        $display("reset mid-stall");
        @(negedge clk);
        rst = 1; clear_inputs();

        // Saturation: 20 stalled cycles against a 4-bit counter.
        do_reset();
        stall_id = 1; rd_en = 2'b10; rd_addr = {5'd9,5'd0}; rf_data = {32'h0,32'h7};
        src_we = 3'b001; src_waddr = {5'd0,5'd0,5'd9}; src_rdy = 3'b000;
        #1;
        chk("sat_stall4", {63'h0, stall4}, 64'h1);
        chk("sat_data4", opnd_data4, {32'h0,32'h7});
        chk("sat_fwd4", {62'h0, opnd_fwd4}, 64'h0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (i == 14) chk("sat_cnt4_14", {60'h0, lu_cnt4}, 64'hE);
            if (i == 15) chk("sat_cnt4_15", {60'h0, lu_cnt4}, 64'hF);
        end
        chk("sat_cnt4_20", {60'h0, lu_cnt4}, 64'hF);
        chk("sat_cnt16_20", {48'h0, lu_cnt}, 64'd20);
        $display("saturation sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
